// File: rtl/gyro_integrator.sv
// Multi-channel gyro rate integrator with bias calibration, deadband, saturating
// accumulators, per-channel zeroing and a registered angle-valid strobe.
//
// state | meaning
// CAL   | averaging 2^CAL_LOG2 samples per channel to form new biases
// RUN   | bias-corrected, deadbanded rates are integrated
module gyro_integrator #(
    parameter int CH        = 3,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 64,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 28,
    parameter int DEADBAND  = 100,
    parameter int CAL_LOG2  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CH*DATA_W-1:0] rate_in,
    input  logic                 rate_valid,
    input  logic                 cal_start,
    input  logic [CH-1:0]        zero,
    output logic [CH*OUT_W-1:0]  angle_out,
    output logic                 angle_valid,
    output logic                 cal_busy,
    output logic [CH-1:0]        sat
);

    localparam int SUM_W = DATA_W + CAL_LOG2;
    localparam logic signed [DATA_W:0] DB_POS = (DATA_W+1)'(DEADBAND);
    localparam logic signed [DATA_W:0] DB_NEG = -DB_POS;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ST_CAL, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [CAL_LOG2-1:0] cnt_q;
    logic                s1_valid_q;
    logic                angle_valid_q;
    logic                cal_take, cal_done, cal_clear, s1_load;

    // A cal_start cycle drops any coincident sample during calibration.
    assign cal_take  = (state_q == ST_CAL) && !cal_start && rate_valid;
    assign cal_done  = cal_take && (cnt_q == {CAL_LOG2{1'b1}});
    assign cal_clear = cal_start || cal_done;
    assign s1_load   = (state_q == ST_RUN) && rate_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CAL:  if (cal_done)  state_d = ST_RUN;
            ST_RUN:  if (cal_start) state_d = ST_CAL;
            default: state_d = ST_CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_CAL;
            cnt_q         <= '0;
            s1_valid_q    <= 1'b0;
            angle_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_valid_q    <= s1_load;
            angle_valid_q <= s1_valid_q;
            if (cal_clear)     cnt_q <= '0;
            else if (cal_take) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cal_busy    = (state_q == ST_CAL);
    assign angle_valid = angle_valid_q;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [DATA_W-1:0] rate, bias_q;
        logic signed [SUM_W-1:0]  sum_q, sum_nxt;
        logic signed [DATA_W:0]   corr, d_nxt, d_q;
        logic signed [ACC_W-1:0]  acc_q, d_ext, acc_nxt;
        logic signed [ACC_W:0]    acc_sum;
        logic                     sat_q, ovf;

        assign rate    = rate_in[k*DATA_W +: DATA_W];
        assign sum_nxt = sum_q + {{CAL_LOG2{rate[DATA_W-1]}}, rate};
        assign corr    = {rate[DATA_W-1], rate} - {bias_q[DATA_W-1], bias_q};
        assign d_nxt   = (corr >= DB_NEG && corr <= DB_POS) ? '0 : corr;

        assign d_ext   = {{(ACC_W-DATA_W-1){d_q[DATA_W]}}, d_q};
        assign acc_sum = {acc_q[ACC_W-1], acc_q} + {d_ext[ACC_W-1], d_ext};
        assign ovf     = acc_sum[ACC_W] != acc_sum[ACC_W-1];
        assign acc_nxt = !ovf ? acc_sum[ACC_W-1:0] : (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX);

        always_ff @(posedge clk) begin
            if (!resetn) begin
                sum_q  <= '0;
                bias_q <= '0;
                d_q    <= '0;
                acc_q  <= '0;
                sat_q  <= 1'b0;
            end else begin
                if (cal_clear)     sum_q <= '0;
                else if (cal_take) sum_q <= sum_nxt;
                // Upper bits of the full sum are the arithmetic-shifted average.
                if (cal_done) bias_q <= sum_nxt[SUM_W-1:CAL_LOG2];
                if (s1_load)  d_q    <= d_nxt;
                if (zero[k]) begin
                    acc_q <= '0;
                    sat_q <= 1'b0;
                end else if (s1_valid_q) begin
                    acc_q <= acc_nxt;
                    if (ovf) sat_q <= 1'b1;
                end
            end
        end

        assign angle_out[k*OUT_W +: OUT_W] = OUT_W'(acc_q >>> OUT_SHIFT);
        assign sat[k] = sat_q;
    end

endmodule

// File: tb/tb_gyro_integrator.sv
// Directed, cycle-accurate vector bench for gyro_integrator with hand-computed
// expectations, plus a hand-written saturation/zeroing sequence.
module tb_gyro_integrator;

    localparam int CH = 3, DATA_W = 16, ACC_W = 20, OUT_W = 16, OUT_SHIFT = 4;
    localparam int DEADBAND = 100, CAL_LOG2 = 2;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [CH*DATA_W-1:0] rate_in = '0;
    logic                 rate_valid = 1'b0;
    logic                 cal_start = 1'b0;
    logic [CH-1:0]        zero = '0;
    logic [CH*OUT_W-1:0]  angle_out;
    logic                 angle_valid;
    logic                 cal_busy;
    logic [CH-1:0]        sat;

    int n_vec = 0;
    int n_err = 0;

    gyro_integrator #(
        .CH(CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .OUT_SHIFT(OUT_SHIFT), .DEADBAND(DEADBAND), .CAL_LOG2(CAL_LOG2)
    ) dut (
        .clk(clk), .resetn(resetn), .rate_in(rate_in), .rate_valid(rate_valid),
        .cal_start(cal_start), .zero(zero), .angle_out(angle_out),
        .angle_valid(angle_valid), .cal_busy(cal_busy), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn, v, cs;
        logic [2:0] z;
        int         r0, r1, r2;
        logic       cb, av;
        int         a0, a1, a2;
        logic [2:0] s;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t mk(logic rstn, logic v, logic cs, logic [2:0] z,
                                int r0, int r1, int r2, logic cb, logic av,
                                int a0, int a1, int a2, logic [2:0] s);
        vec_t t;
        t.rstn = rstn; t.v = v; t.cs = cs; t.z = z;
        t.r0 = r0; t.r1 = r1; t.r2 = r2;
        t.cb = cb; t.av = av; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.s = s;
        return t;
    endfunction

    function automatic int angle(int k);
        logic signed [OUT_W-1:0] a;
        a = angle_out[k*OUT_W +: OUT_W];
        return int'(a);
    endfunction

    task automatic chk(string name, int idx, int got, int exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic drive(logic rstn, logic v, logic cs, logic [2:0] z, int r0, int r1, int r2);
        resetn     = rstn;
        rate_valid = v;
        cal_start  = cs;
        zero       = z;
        rate_in    = {DATA_W'(r2), DATA_W'(r1), DATA_W'(r0)};
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic apply(vec_t t, int idx);
        drive(t.rstn, t.v, t.cs, t.z, t.r0, t.r1, t.r2);
        chk("cal_busy", idx, int'(cal_busy), int'(t.cb));
        chk("angle_valid", idx, int'(angle_valid), int'(t.av));
        chk("angle0", idx, angle(0), t.a0);
        chk("angle1", idx, angle(1), t.a1);
        chk("angle2", idx, angle(2), t.a2);
        chk("sat", idx, int'(sat), int'(t.s));
    endtask

    initial begin
        // reset, calibration (biases 50, -20, 0), integration and deadband
        tbl_a.push_back(mk(0,0,0,3'b000,   0,  0,   0, 1,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,1,0,3'b000,  50,-20,   0, 1,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,1,0,3'b000,  50,-20,   0, 1,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,1,0,3'b000,  50,-20,   0, 1,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,1,0,3'b000,  50,-20,   0, 0,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,0,0,3'b000,   0,  0,   0, 0,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,1,0,3'b000, 250, 80,-101, 0,0,  0,0,  0,3'b000));
        tbl_a.push_back(mk(1,0,0,3'b000,   0,  0,   0, 0,1, 12,0, -7,3'b000));
        tbl_a.push_back(mk(1,1,0,3'b000, 150,-20,   0, 0,0, 12,0, -7,3'b000));
        tbl_a.push_back(mk(1,0,0,3'b000,   0,  0,   0, 0,1, 12,0, -7,3'b000));

        // zero collision, reset mid-calibration, recalibration hold with restart
        tbl_b.push_back(mk(1,1,0,3'b000,  50,480,   0, 0,0,  0,0, -7,3'b000));
        tbl_b.push_back(mk(1,0,0,3'b010,   0,  0,   0, 0,1,  0,0, -7,3'b000));
        tbl_b.push_back(mk(1,0,0,3'b000,   0,  0,   0, 0,0,  0,0, -7,3'b000));
        tbl_b.push_back(mk(1,0,1,3'b000,   0,  0,   0, 1,0,  0,0, -7,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,   7,  7,   7, 1,0,  0,0, -7,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,   7,  7,   7, 1,0,  0,0, -7,3'b000));
        tbl_b.push_back(mk(0,0,0,3'b000,   0,  0,   0, 1,0,  0,0,  0,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  10, 10,  10, 1,0,  0,0,  0,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  10, 10,  10, 1,0,  0,0,  0,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  10, 10,  10, 1,0,  0,0,  0,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  10, 10,  10, 0,0,  0,0,  0,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000, 210,210, 210, 0,0,  0,0,  0,3'b000));
        tbl_b.push_back(mk(1,0,0,3'b000,   0,  0,   0, 0,1, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,0,1,3'b000,   0,  0,   0, 1,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  30, 30,  30, 1,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,1,3'b000, 999,999, 999, 1,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  30, 30,  30, 1,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  30, 30,  30, 1,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  30, 30,  30, 1,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000,  30, 30,  30, 0,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,1,0,3'b000, 250, 30,  30, 0,0, 12,12,12,3'b000));
        tbl_b.push_back(mk(1,0,0,3'b000,   0,  0,   0, 0,1, 26,12,12,3'b000));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], i);

        // saturation: acc0 starts at 200, each add is 32767-50
        begin
            longint exp_acc = 200;
            logic   exp_sat = 1'b0;
            logic signed [OUT_W-1:0] exp_ang;
            for (int i = 0; i < 22; i++) begin
                if (i < 20) drive(1, 1, 0, 3'b000, 32767, -20, 0);
                else        drive(1, 0, 0, 3'b000, 0, 0, 0);
                if (i >= 1 && i <= 20) begin
                    exp_acc = exp_acc + 32717;
                    if (exp_acc > 524287) begin
                        exp_acc = 524287;
                        exp_sat = 1'b1;
                    end
                end
                exp_ang = OUT_W'(exp_acc >>> OUT_SHIFT);
                chk("sat_av", 100 + i, int'(angle_valid), (i >= 1 && i <= 20) ? 1 : 0);
                chk("sat_angle0", 100 + i, angle(0), int'(exp_ang));
                chk("sat_flag", 100 + i, int'(sat), int'({2'b00, exp_sat}));
                chk("sat_angle2", 100 + i, angle(2), -7);
            end
            chk("sat_final", 130, angle(0), 32767);
            drive(1, 0, 0, 3'b001, 0, 0, 0);
            chk("zero_angle0", 131, angle(0), 0);
            chk("zero_sat", 131, int'(sat), 0);
            chk("zero_angle1", 131, angle(1), 0);
            chk("zero_angle2", 131, angle(2), -7);
            drive(1, 0, 0, 3'b000, 0, 0, 0);
        end

        for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], 200 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
